// File: rtl/fifomem_arb.sv
// fifomem_arb: round-robin arbiter with bounded burst sharing one memory port
// between two single-beat read/write requesters. Read data comes back one
// cycle after the grant, relying on the memory's registered read port.
module fifomem_arb #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 4,
  parameter int unsigned MAXBURST = 2
) (
  input  logic                clk,
  input  logic                arst,
  // requester 0
  input  logic                r0_valid,
  output logic                r0_ready,
  input  logic                r0_write,
  input  logic [ADDRSIZE-1:0] r0_addr,
  input  logic [DATASIZE-1:0] r0_wdata,
  output logic                r0_rvalid,
  output logic [DATASIZE-1:0] r0_rdata,
  // requester 1
  input  logic                r1_valid,
  output logic                r1_ready,
  input  logic                r1_write,
  input  logic [ADDRSIZE-1:0] r1_addr,
  input  logic [DATASIZE-1:0] r1_wdata,
  output logic                r1_rvalid,
  output logic [DATASIZE-1:0] r1_rdata,
  // memory port a
  output logic [ADDRSIZE-1:0] mem_addr,
  output logic [DATASIZE-1:0] mem_wdata,
  output logic                mem_winc,
  output logic                mem_rinc,
  input  logic [DATASIZE-1:0] mem_rdata
);

  localparam int unsigned    CNTW    = $clog2(MAXBURST + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAXBURST);

  logic            r_last;
  logic [CNTW-1:0] r_cnt;
  logic            r_rvalid0;
  logic            r_rvalid1;

  logic w_gnt0;
  logic w_gnt1;
  logic w_any;
  logic w_burst;
  logic w_write;

  // A burst keeps going only while it has started and is below its cap
  assign w_burst = (r_cnt != '0) && (r_cnt < CNT_MAX);

  // Grant selection; reset forces all grants low
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!arst) begin
      if (r0_valid && r1_valid) begin
        if (w_burst) begin
          w_gnt0 = ~r_last;
          w_gnt1 = r_last;
        end else begin
          w_gnt0 = r_last;
          w_gnt1 = ~r_last;
        end
      end else begin
        w_gnt0 = r0_valid;
        w_gnt1 = r1_valid;
      end
    end
  end

  assign w_any   = w_gnt0 | w_gnt1;
  assign w_write = w_gnt1 ? r1_write : r0_write;

  assign r0_ready  = w_gnt0;
  assign r1_ready  = w_gnt1;
  assign mem_addr  = w_gnt1 ? r1_addr  : r0_addr;
  assign mem_wdata = w_gnt1 ? r1_wdata : r0_wdata;
  assign mem_winc  = w_any & w_write;
  assign mem_rinc  = w_any & ~w_write;

  assign r0_rvalid = r_rvalid0;
  assign r1_rvalid = r_rvalid1;
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

  // Round-robin history, burst count and read-response flags
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~r0_write;
      r_rvalid1 <= w_gnt1 & ~r1_write;
      if (w_any) begin
        if (w_gnt1 == r_last) begin
          r_cnt <= (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + CNTW'(1);
        end else begin
          r_last <= w_gnt1;
          r_cnt  <= CNTW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifomem_arb.sv
// tb_fifomem_arb: directed vector table, hand-written corner sequences and a
// randomized run against a history-based reference model. A small registered
// read memory stands in for fifomem_dp port a.
module tb_fifomem_arb;

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 4;
  localparam int          MAXB = 2;

  logic          clk;
  logic          arst;
  logic          v0, w0, v1, w1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          rdy0, rdy1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_winc, m_rinc;
  // second instance with MAXBURST=1
  logic          b_rdy0, b_rdy1, b_rv0, b_rv1, b_winc, b_rinc;
  logic [DW-1:0] b_rd0, b_rd1, b_wdata;
  logic [AW-1:0] b_addr;

  int n_cmp = 0;
  int n_err = 0;

  fifomem_arb #(.DATASIZE(DW), .ADDRSIZE(AW), .MAXBURST(MAXB)) dut (
    .clk(clk), .arst(arst),
    .r0_valid(v0), .r0_ready(rdy0), .r0_write(w0), .r0_addr(a0), .r0_wdata(d0),
    .r0_rvalid(rv0), .r0_rdata(rd0),
    .r1_valid(v1), .r1_ready(rdy1), .r1_write(w1), .r1_addr(a1), .r1_wdata(d1),
    .r1_rvalid(rv1), .r1_rdata(rd1),
    .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_winc(m_winc), .mem_rinc(m_rinc),
    .mem_rdata(m_rdata)
  );

  fifomem_arb #(.DATASIZE(DW), .ADDRSIZE(AW), .MAXBURST(1)) dut_rr (
    .clk(clk), .arst(arst),
    .r0_valid(v0), .r0_ready(b_rdy0), .r0_write(w0), .r0_addr(a0), .r0_wdata(d0),
    .r0_rvalid(b_rv0), .r0_rdata(b_rd0),
    .r1_valid(v1), .r1_ready(b_rdy1), .r1_write(w1), .r1_addr(a1), .r1_wdata(d1),
    .r1_rvalid(b_rv1), .r1_rdata(b_rd1),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_winc(b_winc), .mem_rinc(b_rinc),
    .mem_rdata(8'h00)
  );

  function automatic logic [7:0] init_val(int i);
    return 8'((i + 1) * 15);
  endfunction

  // Registered-read memory behaving like fifomem_dp port a (non-fallthrough)
  logic [DW-1:0] fmem [16];
  initial begin
    m_rdata = '0;
    for (int i = 0; i < 16; i++) fmem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (m_winc) fmem[m_addr] <= m_wdata;
      if (m_rinc) m_rdata <= fmem[m_addr];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit c_rst, bit c_v0, bit c_w0, logic [3:0] c_a0, logic [7:0] c_d0,
                       bit c_v1, bit c_w1, logic [3:0] c_a1, logic [7:0] c_d1);
    arst = c_rst;
    v0 = c_v0; w0 = c_w0; a0 = c_a0; d0 = c_d0;
    v1 = c_v1; w1 = c_w1; a1 = c_a1; d1 = c_d1;
  endtask

  typedef struct {
    bit         rst;
    bit         v0, w0;
    logic [3:0] a0;
    logic [7:0] d0;
    bit         v1, w1;
    logic [3:0] a1;
    logic [7:0] d1;
    bit         g0, g1;
    bit         rv0, rv1;
    logic [7:0] rd;
  } vec_t;

  function automatic vec_t mk(bit c_rst, bit c_v0, bit c_w0, int c_a0, int c_d0,
                              bit c_v1, bit c_w1, int c_a1, int c_d1,
                              bit c_g0, bit c_g1, bit c_rv0, bit c_rv1, int c_rd);
    vec_t t;
    t.rst = c_rst;
    t.v0 = c_v0; t.w0 = c_w0; t.a0 = 4'(c_a0); t.d0 = 8'(c_d0);
    t.v1 = c_v1; t.w1 = c_w1; t.a1 = 4'(c_a1); t.d1 = 8'(c_d1);
    t.g0 = c_g0; t.g1 = c_g1; t.rv0 = c_rv0; t.rv1 = c_rv1; t.rd = 8'(c_rd);
    return t;
  endfunction

  // Reference model state: grant history since the last reset (-1 = idle)
  int            hist[$];
  logic [DW-1:0] ref_mem [16];

  function automatic int model_grant(bit c0, bit c1);
    int last;
    int run;
    if (!c0 && !c1) return -1;
    if (c0 && !c1) return 0;
    if (!c0 && c1) return 1;
    last = 1;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k] >= 0) begin
        last = hist[k];
        break;
      end
    end
    run = 0;
    for (int k = hist.size() - 1; k >= 0; k--) begin
      if (hist[k] != last) break;
      run++;
    end
    if (run >= 1 && run < MAXB) return last;
    return 1 - last;
  endfunction

  vec_t tbl [24];

  initial begin
    // directed vectors: {inputs, expected grants, expected response next cycle}
    tbl[0]  = mk(0, 1,1,3,'hA5, 0,0,0,0,   1,0, 0,0,0);
    tbl[1]  = mk(0, 1,0,3,0,    0,0,0,0,   1,0, 1,0,'hA5);
    tbl[2]  = mk(0, 0,0,0,0,    0,0,0,0,   0,0, 0,0,0);
    tbl[3]  = mk(1, 1,0,5,0,    1,0,6,0,   0,0, 0,0,0);
    tbl[4]  = mk(0, 1,0,0,0,    1,0,8,0,   1,0, 1,0,'h0F);
    tbl[5]  = mk(0, 1,0,1,0,    1,0,8,0,   1,0, 1,0,'h1E);
    tbl[6]  = mk(0, 1,0,2,0,    1,0,8,0,   0,1, 0,1,'h87);
    tbl[7]  = mk(0, 1,0,2,0,    1,0,9,0,   0,1, 0,1,'h96);
    tbl[8]  = mk(0, 1,0,2,0,    1,0,10,0,  1,0, 1,0,'h2D);
    tbl[9]  = mk(0, 1,0,3,0,    1,0,10,0,  1,0, 1,0,'hA5);
    tbl[10] = mk(0, 0,0,0,0,    0,0,0,0,   0,0, 0,0,0);
    tbl[11] = mk(0, 1,0,4,0,    0,0,0,0,   1,0, 1,0,'h4B);
    tbl[12] = mk(0, 0,0,0,0,    0,0,0,0,   0,0, 0,0,0);
    tbl[13] = mk(0, 1,0,5,0,    1,0,11,0,  0,1, 0,1,'hB4);
    tbl[14] = mk(0, 1,0,5,0,    0,0,0,0,   1,0, 1,0,'h5A);
    tbl[15] = mk(0, 1,0,6,0,    0,0,0,0,   1,0, 1,0,'h69);
    tbl[16] = mk(0, 1,0,0,0,    0,0,0,0,   1,0, 1,0,'h0F);
    tbl[17] = mk(0, 1,0,1,0,    0,0,0,0,   1,0, 1,0,'h1E);
    tbl[18] = mk(0, 1,0,2,0,    0,0,0,0,   1,0, 1,0,'h2D);
    tbl[19] = mk(0, 1,0,8,0,    1,0,13,0,  0,1, 0,1,'hD2);
    tbl[20] = mk(0, 0,0,0,0,    0,0,0,0,   0,0, 0,0,0);
    tbl[21] = mk(0, 1,1,7,'h3C, 1,0,7,0,   1,0, 0,0,0);
    tbl[22] = mk(0, 0,0,0,0,    1,0,7,0,   0,1, 0,1,'h3C);
    tbl[23] = mk(0, 0,0,0,0,    0,0,0,0,   0,0, 0,0,0);

    // reset state, with both requesters valid
    drive(1, 1,0,1,0, 1,1,2,8'h11);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy0", 32'(rdy0), 32'(0));
    chk("rst_rdy1", 32'(rdy1), 32'(0));
    chk("rst_winc", 32'(m_winc), 32'(0));
    chk("rst_rinc", 32'(m_rinc), 32'(0));
    chk("rst_rv0", 32'(rv0), 32'(0));
    chk("rst_rv1", 32'(rv1), 32'(0));

    // table-driven directed run
    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      #1;
      chk($sformatf("tbl%0d_rdy0", i), 32'(rdy0), 32'(tbl[i].g0));
      chk($sformatf("tbl%0d_rdy1", i), 32'(rdy1), 32'(tbl[i].g1));
      chk($sformatf("tbl%0d_winc", i), 32'(m_winc),
          32'((tbl[i].g0 & tbl[i].w0) | (tbl[i].g1 & tbl[i].w1)));
      chk($sformatf("tbl%0d_rinc", i), 32'(m_rinc),
          32'((tbl[i].g0 & ~tbl[i].w0) | (tbl[i].g1 & ~tbl[i].w1)));
      if (tbl[i].g0 || tbl[i].g1)
        chk($sformatf("tbl%0d_addr", i), 32'(m_addr), 32'(tbl[i].g1 ? tbl[i].a1 : tbl[i].a0));
      @(negedge clk);
      chk($sformatf("tbl%0d_rv0", i), 32'(rv0), 32'(tbl[i].rv0));
      chk($sformatf("tbl%0d_rv1", i), 32'(rv1), 32'(tbl[i].rv1));
      if (tbl[i].rv0) chk($sformatf("tbl%0d_rd0", i), 32'(rd0), 32'(tbl[i].rd));
      if (tbl[i].rv1) chk($sformatf("tbl%0d_rd1", i), 32'(rd1), 32'(tbl[i].rd));
    end

    // MAXBURST=1 instance alternates strictly under contention
    drive(1, 1,0,0,0, 1,0,1,0);
    @(negedge clk);
    drive(0, 1,0,0,0, 1,0,1,0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_rdy0", k), 32'(b_rdy0), 32'((k % 2) == 0));
      chk($sformatf("rr%0d_rdy1", k), 32'(b_rdy1), 32'((k % 2) == 1));
      @(negedge clk);
    end

    // reset asserted in the cycle a read is granted
    drive(1, 0,0,0,0, 0,0,0,0);
    @(negedge clk);
    drive(0, 1,0,3,0, 0,0,0,0);
    #1;
    chk("rstmid_rdy0_pre", 32'(rdy0), 32'(1));
    chk("rstmid_rinc_pre", 32'(m_rinc), 32'(1));
    #1;
    arst = 1'b1;
    #1;
    chk("rstmid_rdy0", 32'(rdy0), 32'(0));
    chk("rstmid_rinc", 32'(m_rinc), 32'(0));
    chk("rstmid_winc", 32'(m_winc), 32'(0));
    @(negedge clk);
    chk("rstmid_rv0", 32'(rv0), 32'(0));
    drive(0, 1,0,1,0, 1,0,2,0);
    #1;
    chk("rstmid_first_rdy0", 32'(rdy0), 32'(1));
    chk("rstmid_first_rdy1", 32'(rdy1), 32'(0));
    @(negedge clk);
    chk("rstmid_first_rv0", 32'(rv0), 32'(1));
    chk("rstmid_first_rd0", 32'(rd0), 32'(8'h1E));

    // randomized run against the history-based reference model
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    ref_mem[3] = 8'hA5;
    ref_mem[7] = 8'h3C;
    drive(1, 0,0,0,0, 0,0,0,0);
    hist.delete();
    begin
      bit            pend0, pend1, rr, vv0, ww0, vv1, ww1;
      logic [3:0]    aa0, aa1;
      logic [7:0]    dd0, dd1, pdata;
      int            g;
      pend0 = 1'b0;
      pend1 = 1'b0;
      pdata = '0;
      @(negedge clk);
      for (int c = 0; c < 600; c++) begin
        chk("rnd_rv0", 32'(rv0), 32'(pend0));
        chk("rnd_rv1", 32'(rv1), 32'(pend1));
        if (pend0) chk("rnd_rd0", 32'(rd0), 32'(pdata));
        if (pend1) chk("rnd_rd1", 32'(rd1), 32'(pdata));
        rr  = (c > 0) && ($urandom_range(0, 59) == 0);
        vv0 = ($urandom_range(0, 3) != 0);
        vv1 = ($urandom_range(0, 3) != 0);
        ww0 = $urandom_range(0, 1) == 1;
        ww1 = $urandom_range(0, 1) == 1;
        aa0 = 4'($urandom_range(0, 3));
        aa1 = 4'($urandom_range(0, 3));
        dd0 = 8'($urandom);
        dd1 = 8'($urandom);
        drive(rr, vv0, ww0, aa0, dd0, vv1, ww1, aa1, dd1);
        #1;
        g = rr ? -1 : model_grant(vv0, vv1);
        chk("rnd_rdy0", 32'(rdy0), 32'(g == 0));
        chk("rnd_rdy1", 32'(rdy1), 32'(g == 1));
        chk("rnd_winc", 32'(m_winc), 32'((g == 0 && ww0) || (g == 1 && ww1)));
        chk("rnd_rinc", 32'(m_rinc), 32'((g == 0 && !ww0) || (g == 1 && !ww1)));
        pend0 = 1'b0;
        pend1 = 1'b0;
        if (rr) begin
          hist.delete();
        end else if (g < 0) begin
          hist.push_back(-1);
        end else begin
          hist.push_back(g);
          chk("rnd_addr", 32'(m_addr), 32'(g == 1 ? aa1 : aa0));
          if (g == 0 && ww0) begin
            chk("rnd_wdata", 32'(m_wdata), 32'(dd0));
            ref_mem[aa0] = dd0;
          end else if (g == 1 && ww1) begin
            chk("rnd_wdata", 32'(m_wdata), 32'(dd1));
            ref_mem[aa1] = dd1;
          end else begin
            pdata = ref_mem[g == 1 ? aa1 : aa0];
            pend0 = (g == 0);
            pend1 = (g == 1);
          end
        end
        @(negedge clk);
      end
      chk("rnd_end_rv0", 32'(rv0), 32'(pend0));
      chk("rnd_end_rv1", 32'(rv1), 32'(pend1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifomem_arb.md
# fifomem_arb

Single-clock two-requester arbiter that shares one port of `fifomem_dp` (instantiated with `FALLTHROUGH="FALSE"`, registered read) between two independent masters. Each master issues single-beat read or write commands over a valid/ready handshake. Grants are round-robin with a bounded burst allowance. Read data returns to the master that issued the read exactly one cycle after the grant. The block drives the memory's `a_*` port; the `b_*` port belongs to other logic.

## Interface

Parameters:
- `DATASIZE`, 8: memory word width.
- `ADDRSIZE`, 4: memory address width.
- `MAXBURST`, 2: maximum consecutive grants to one requester while the other is waiting. Must be ≥ 1; 1 gives pure round-robin.

Ports:
- `clk`  in  1  single clock for the block and the memory port.
- `arst`  in  1  asynchronous reset, active-high.
- `r0_valid`  in  1  requester 0 command valid.
- `r0_ready`  out  1  requester 0 command accepted this cycle (grant).
- `r0_write`  in  1  1 = write, 0 = read.
- `r0_addr`  in  ADDRSIZE  command address.
- `r0_wdata`  in  DATASIZE  write data.
- `r0_rvalid`  out  1  read response valid.
- `r0_rdata`  out  DATASIZE  read response data.
- `r1_*`  same set for requester 1.
- `mem_addr`  out  ADDRSIZE  to memory `a_addr`.
- `mem_wdata`  out  DATASIZE  to memory `a_wdata`.
- `mem_winc`  out  1  to memory `a_winc`.
- `mem_rinc`  out  1  to memory `a_rinc`.
- `mem_rdata`  in  DATASIZE  from memory `a_rdata`.

## Operation

State:
- `last`: index of the requester most recently granted. Reset value 1, so r0 wins the first contention.
- `cnt`: consecutive grants to `last`. Width `$clog2(MAXBURST+1)`. Reset value 0.
- `rvalid0`, `rvalid1`: response flags. Reset value 0.

Grant selection is combinational and made each cycle:
- Neither requester valid: no grant.
- Exactly one requester valid: grant it.
- Both valid, with `cnt != 0` and `cnt < MAXBURST`: grant `last` (burst continues).
- Both valid, otherwise: grant `!last`.
- `rN_ready` = grant to requester N. A command transfers when `rN_valid & rN_ready`. Ready is never asserted without valid.

Memory drive:
- The granted requester's addr and wdata are muxed to `mem_addr` and `mem_wdata`.
- `mem_winc` = grant & write.
- `mem_rinc` = grant & !write.
- With no grant, both inc signals are 0; addr and wdata are don't-care (mux to r0).

State update at each rising edge of `clk`:
- Granted N equal to `last`: `cnt <= min(cnt+1, MAXBURST)`.
- Granted N not equal to `last`: `last <= N`, `cnt <= 1`.
- No grant: `cnt <= 0`. An idle cycle ends the burst; `last` is unchanged.
- `rvalidN <= grant to N & !rN_write`.

Read responses:
- `rN_rvalid = rvalidN`.
- `r0_rdata = r1_rdata = mem_rdata`. The data is meaningful only while the corresponding rvalid is high.
- Responses have no backpressure. A requester must accept rdata on the cycle rvalid is high.

Hazards:
- A read and a write to the same address are serialised by the arbiter, in grant order.
- A read granted one cycle after a write to the same address returns the new data.

Reset:
- While `arst` is high, all grants, `rN_ready`, `mem_winc` and `mem_rinc` are forced to 0 combinationally.
- `rvalidN`, `last` and `cnt` clear asynchronously.
- A response pending at reset assertion is dropped.
- The first grant can occur on the first rising edge after `arst` deasserts.

## Timing

- Command-to-grant: 0 cycles when uncontested. Under contention, worst-case wait is `MAXBURST` cycles.
- Read latency: grant edge T → `rN_rvalid` high for exactly cycle T+1 with valid `rN_rdata`. This relies on the memory's registered `a_rdata`.
- Back-to-back reads by one requester give back-to-back rvalid, one per cycle.
- Writes complete at the grant edge and produce no response.
- Throughput: one command per cycle aggregate.
- Reset values of outputs: `r0_ready`, `r1_ready`, `r0_rvalid`, `r1_rvalid`, `mem_winc`, `mem_rinc` = 0. `rdata` follows `mem_rdata`.

## Test plan

Benches use `MAXBURST=2`, `DATASIZE=8`, `ADDRSIZE=4`, connected to `fifomem_dp` with `FALLTHROUGH="FALSE"`.

1. **Uncontested write then read.** r0 writes 0xA5 at addr 3, then reads addr 3 → `r0_ready` high each cycle; `r0_rvalid` high one cycle after the read grant with `r0_rdata` = 0xA5; `r1_rvalid` stays 0.
2. **First contention after reset.** Both requesters hold valid, r0 reading addrs 0,1,2,… and r1 reading addrs 8,9,… → grant sequence r0,r0,r1,r1,r0,r0. Each rvalid pulses on the matching requester one cycle later with the correct data.
3. **MAXBURST=1 regression.** Both requesters hold valid → strict alternation r0,r1,r0,r1.
4. **Idle cycle ends burst.** r0 granted once, both idle for one cycle, then both valid → r1 granted first (`cnt` reset to 0, `last`=0). A sole valid r0 streaming 5 beats gets 5 consecutive grants, with `cnt` saturating at 2.
5. **Same-address ordering.** Same cycle: r0 writes 0x3C at addr 7, r1 reads addr 7, with `last`=1 → r0 granted first, r1 next cycle. `r1_rdata` = 0x3C.
6. **Reset mid-operation.** Assert `arst` in the cycle a read is granted → `r0_rvalid` stays 0; `ready`, `winc`, `rinc` drop immediately. After release, both valid → r0 granted first.
